// File: rtl/jzjpcc_pkg.sv
// Shared types and helpers for the jzjpcc memory stage: funct3 encodings,
// FSM states, store size masks and the alignment/legality check.
package jzjpcc_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LD  = 3'd3,
    LBU = 3'd4,
    LHU = 3'd5,
    LWU = 3'd6
  } load_f3_t;

  typedef enum logic [2:0] {
    SB = 3'd0,
    SH = 3'd1,
    SW = 3'd2,
    SD = 3'd3
  } store_f3_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN
  } mem_state_t;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    return MASK_B;
      2'd1:    return MASK_H;
      2'd2:    return MASK_W;
      default: return MASK_D;
    endcase
  endfunction

  // Illegal funct3 values are folded into the misaligned trap.
  function automatic logic access_bad(input logic       is_load,
                                      input logic       is_store,
                                      input logic [2:0] f3,
                                      input logic [2:0] lo,
                                      input logic       wide);
    logic bad;
    bad = 1'b0;
    if (is_load) begin
      case (f3)
        LB, LBU:  bad = 1'b0;
        LH, LHU:  bad = lo[0];
        LW:       bad = (lo[1:0] != 2'b00);
        LWU:      bad = !wide || (lo[1:0] != 2'b00);
        LD:       bad = !wide || (lo != 3'b000);
        default:  bad = 1'b1;
      endcase
    end else if (is_store) begin
      case (f3)
        SB:       bad = 1'b0;
        SH:       bad = lo[0];
        SW:       bad = (lo[1:0] != 2'b00);
        SD:       bad = !wide || (lo != 3'b000);
        default:  bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/jzjpcc_load_align.sv
// Load data alignment: picks the addressed lane out of the bus word and
// sign- or zero-extends it according to the load funct3.
module jzjpcc_load_align
  import jzjpcc_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]               rdata,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]     offset,
  input  logic [2:0]                          funct3,
  output logic [DATA_WIDTH-1:0]               result
);

  logic [DATA_WIDTH-1:0] lane;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    lane   = rdata >> {offset, 3'b000};
    result = lane;
    case (funct3)
      LB:      result = DATA_WIDTH'($signed(lane[7:0]));
      LH:      result = DATA_WIDTH'($signed(lane[15:0]));
      LW:      result = DATA_WIDTH'($signed(lane[31:0]));
      LBU:     result = DATA_WIDTH'(lane[7:0]);
      LHU:     result = DATA_WIDTH'(lane[15:0]);
      LWU:     result = DATA_WIDTH'(lane[31:0]);
      default: result = lane;
    endcase
  end

endmodule

// File: rtl/jzjpcc_memory_stage.sv
// jzjpcc memory stage: holds one execute-stage op, issues it over a valid/ready
// memory bus, stalls execute until it completes and emits a registered WB bundle.
module jzjpcc_memory_stage
  import jzjpcc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        ex_valid,
  input  logic                                        ex_is_load,
  input  logic                                        ex_is_store,
  input  logic [2:0]                                  ex_funct3,
  input  logic [ADDR_WIDTH-1:0]                       ex_addr,
  input  logic [DATA_WIDTH-1:0]                       ex_store_data,
  input  logic [DATA_WIDTH-1:0]                       ex_alu_result,
  input  logic [4:0]                                  ex_rd_addr,
  input  logic                                        ex_rd_we,
  input  logic                                        flush,
  output logic                                        ex_stall,
  output logic                                        mem_req_valid,
  input  logic                                        mem_req_ready,
  output logic                                        mem_req_write,
  output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0]  mem_req_addr,
  output logic [DATA_WIDTH-1:0]                       mem_req_wdata,
  output logic [DATA_WIDTH/8-1:0]                     mem_req_bytemask,
  input  logic                                        mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]                       mem_rsp_rdata,
  output logic                                        wb_valid,
  output logic [4:0]                                  wb_rd_addr,
  output logic                                        wb_rd_we,
  output logic [DATA_WIDTH-1:0]                       wb_rd_data,
  output logic                                        wb_misaligned
);

  localparam int   BYTES = DATA_WIDTH / 8;
  localparam int   OFFS  = $clog2(BYTES);
  localparam logic WIDE  = (DATA_WIDTH == 64);

  typedef struct packed {
    logic                  valid;
    logic                  is_load;
    logic                  is_store;
    logic                  bad;
    logic [2:0]            funct3;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] alu;
    logic [4:0]            rd_addr;
    logic                  rd_we;
  } m_op_t;

  mem_state_t            state_q, state_d;
  m_op_t                 m_q, m_d, ex_op;
  logic                  m_done, m_retire, capture;
  logic [DATA_WIDTH-1:0] load_data;
  logic [15:0]           mask_wide;

  logic                  wb_valid_q, wb_valid_d;
  logic [4:0]            wb_rd_addr_q, wb_rd_addr_d;
  logic                  wb_rd_we_q, wb_rd_we_d;
  logic [DATA_WIDTH-1:0] wb_rd_data_q, wb_rd_data_d;
  logic                  wb_misaligned_q, wb_misaligned_d;

  jzjpcc_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
    .rdata  (mem_rsp_rdata),
    .offset (m_q.addr[OFFS-1:0]),
    .funct3 (m_q.funct3),
    .result (load_data)
  );

  always_comb begin
    ex_op          = '0;
    ex_op.valid    = 1'b1;
    ex_op.is_load  = ex_is_load;
    ex_op.is_store = ex_is_store & ~ex_is_load;
    ex_op.funct3   = ex_funct3;
    ex_op.addr     = ex_addr;
    ex_op.wdata    = ex_store_data;
    ex_op.alu      = ex_alu_result;
    ex_op.rd_addr  = ex_rd_addr;
    ex_op.rd_we    = ex_rd_we;
    ex_op.bad      = access_bad(ex_op.is_load, ex_op.is_store, ex_funct3,
                                ex_addr[2:0], WIDE);
  end

  // m_done: the op leaves M this cycle; m_retire: it leaves with a writeback.
  always_comb begin
    state_d       = state_q;
    m_done        = 1'b0;
    m_retire      = 1'b0;
    mem_req_valid = 1'b0;
    ex_stall      = 1'b0;
    unique case (state_q)
      IDLE: begin
        m_done   = m_q.valid;
        m_retire = m_q.valid & ~flush;
      end
      REQ: begin
        mem_req_valid = ~flush | mem_req_ready;
        if (mem_req_ready) begin
          if (m_q.is_load) begin
            state_d  = flush ? DRAIN : WAIT;
            m_done   = flush;
            ex_stall = 1'b1;
          end else begin
            state_d  = IDLE;
            m_done   = 1'b1;
            m_retire = ~flush;
          end
        end else if (flush) begin
          state_d = IDLE;
          m_done  = 1'b1;
        end else begin
          ex_stall = 1'b1;
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          state_d  = IDLE;
          m_done   = 1'b1;
          m_retire = ~flush;
        end else if (flush) begin
          state_d  = DRAIN;
          m_done   = 1'b1;
          ex_stall = 1'b1;
        end else begin
          ex_stall = 1'b1;
        end
      end
      DRAIN: begin
        ex_stall = 1'b1;
        if (mem_rsp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    capture = ex_valid & ~ex_stall & ~flush;
    m_d     = m_q;
    if (capture) begin
      m_d     = ex_op;
      state_d = ((ex_op.is_load | ex_op.is_store) & ~ex_op.bad) ? REQ : IDLE;
    end else if (m_done) begin
      m_d.valid = 1'b0;
    end
  end

  always_comb begin
    mem_req_write    = m_q.is_store;
    mem_req_addr     = m_q.addr[ADDR_WIDTH-1:OFFS];
    mem_req_wdata    = '0;
    for (int i = 0; i < BYTES; i++) begin
      mem_req_wdata[i*8 +: 8] =
        m_q.wdata[(i & ((1 << m_q.funct3[1:0]) - 1)) * 8 +: 8];
    end
    mask_wide        = {8'h00, size_mask(m_q.funct3[1:0])} << m_q.addr[OFFS-1:0];
    mem_req_bytemask = m_q.is_store ? mask_wide[BYTES-1:0] : '1;
  end

  always_comb begin
    wb_valid_d      = m_retire;
    wb_rd_addr_d    = m_retire ? m_q.rd_addr : 5'd0;
    wb_rd_we_d      = m_retire & m_q.rd_we & ~m_q.bad & ~m_q.is_store;
    wb_misaligned_d = m_retire & m_q.bad;
    wb_rd_data_d    = '0;
    if (m_retire) begin
      if (m_q.bad)          wb_rd_data_d = DATA_WIDTH'(m_q.addr);
      else if (m_q.is_load) wb_rd_data_d = load_data;
      else                  wb_rd_data_d = m_q.alu;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      m_q             <= '0;
      wb_valid_q      <= 1'b0;
      wb_rd_addr_q    <= 5'd0;
      wb_rd_we_q      <= 1'b0;
      wb_rd_data_q    <= '0;
      wb_misaligned_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      m_q             <= m_d;
      wb_valid_q      <= wb_valid_d;
      wb_rd_addr_q    <= wb_rd_addr_d;
      wb_rd_we_q      <= wb_rd_we_d;
      wb_rd_data_q    <= wb_rd_data_d;
      wb_misaligned_q <= wb_misaligned_d;
    end
  end

  assign wb_valid      = wb_valid_q;
  assign wb_rd_addr    = wb_rd_addr_q;
  assign wb_rd_we      = wb_rd_we_q;
  assign wb_rd_data    = wb_rd_data_q;
  assign wb_misaligned = wb_misaligned_q;

endmodule

// File: tb/tb_jzjpcc_memory_stage.sv
// Directed testbench for jzjpcc_memory_stage (32-bit configuration) with
// hand-computed expected values checked through immediate assertions.
module tb_jzjpcc_memory_stage;

  logic        clock;
  logic        reset;
  logic        ex_valid, ex_is_load, ex_is_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_store_data, ex_alu_result;
  logic [4:0]  ex_rd_addr;
  logic        ex_rd_we, flush, ex_stall;
  logic        mem_req_valid, mem_req_ready, mem_req_write;
  logic [29:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_bytemask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        wb_valid, wb_rd_we, wb_misaligned;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_data;

  int n_vec = 0;
  int n_err = 0;

  jzjpcc_memory_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clock            (clock),
    .reset            (reset),
    .ex_valid         (ex_valid),
    .ex_is_load       (ex_is_load),
    .ex_is_store      (ex_is_store),
    .ex_funct3        (ex_funct3),
    .ex_addr          (ex_addr),
    .ex_store_data    (ex_store_data),
    .ex_alu_result    (ex_alu_result),
    .ex_rd_addr       (ex_rd_addr),
    .ex_rd_we         (ex_rd_we),
    .flush            (flush),
    .ex_stall         (ex_stall),
    .mem_req_valid    (mem_req_valid),
    .mem_req_ready    (mem_req_ready),
    .mem_req_write    (mem_req_write),
    .mem_req_addr     (mem_req_addr),
    .mem_req_wdata    (mem_req_wdata),
    .mem_req_bytemask (mem_req_bytemask),
    .mem_rsp_valid    (mem_rsp_valid),
    .mem_rsp_rdata    (mem_rsp_rdata),
    .wb_valid         (wb_valid),
    .wb_rd_addr       (wb_rd_addr),
    .wb_rd_we         (wb_rd_we),
    .wb_rd_data       (wb_rd_data),
    .wb_misaligned    (wb_misaligned)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_ex(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] alu, input logic [4:0] rd, input logic we);
    ex_valid      = 1'b1;
    ex_is_load    = ld;
    ex_is_store   = st;
    ex_funct3     = f3;
    ex_addr       = addr;
    ex_store_data = sdata;
    ex_alu_result = alu;
    ex_rd_addr    = rd;
    ex_rd_we      = we;
  endtask

  task automatic idle_ex();
    ex_valid    = 1'b0;
    ex_is_load  = 1'b0;
    ex_is_store = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    idle_ex();
    ex_funct3 = 3'd0; ex_addr = '0; ex_store_data = '0; ex_alu_result = '0;
    ex_rd_addr = '0; ex_rd_we = 1'b0; flush = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;

    // Reset state
    #12;
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_we", wb_rd_we, 0);
    check("rst_wb_mis", wb_misaligned, 0);
    check("rst_wb_data", wb_rd_data, 0);
    check("rst_wb_rd", wb_rd_addr, 0);
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_stall", ex_stall, 0);
    @(negedge clock);
    reset = 1'b1;
    tick();

    // 1: ALU op retires one cycle after capture
    drive_ex(0, 0, 3'd0, 32'h0, 32'h0, 32'h1234, 5'd5, 1'b1);
    #1 check("t1_stall", ex_stall, 0);
    tick();
    idle_ex();
    #1 check("t1_noreq", mem_req_valid, 0);
    check("t1_wb_early", wb_valid, 0);
    tick();
    check("t1_wb_valid", wb_valid, 1);
    check("t1_wb_rd", wb_rd_addr, 5);
    check("t1_wb_data", wb_rd_data, 32'h1234);
    check("t1_wb_we", wb_rd_we, 1);
    check("t1_wb_mis", wb_misaligned, 0);
    tick();
    check("t1_wb_once", wb_valid, 0);

    // 2: SB 0x103 with ready already high
    mem_req_ready = 1'b1;
    drive_ex(0, 1, 3'd0, 32'h103, 32'h000000AB, 32'h0, 5'd0, 1'b0);
    tick();
    idle_ex();
    #1 check("t2_req_valid", mem_req_valid, 1);
    check("t2_write", mem_req_write, 1);
    check("t2_addr", mem_req_addr, 30'h40);
    check("t2_mask", mem_req_bytemask, 4'b1000);
    check("t2_wdata", mem_req_wdata, 32'hABABABAB);
    check("t2_stall", ex_stall, 0);
    tick();
    check("t2_wb_valid", wb_valid, 1);
    check("t2_wb_we", wb_rd_we, 0);
    check("t2_req_done", mem_req_valid, 0);
    check("t2_stall_after", ex_stall, 0);

    // SH 0x102: halfword replicated into upper lanes
    drive_ex(0, 1, 3'd1, 32'h102, 32'h12345678, 32'h0, 5'd0, 1'b0);
    tick();
    idle_ex();
    #1 check("sh_mask", mem_req_bytemask, 4'b1100);
    check("sh_wdata", mem_req_wdata, 32'h56785678);
    tick();
    check("sh_wb_valid", wb_valid, 1);

    // 3: LB 0x102 with ready held off two cycles
    mem_req_ready = 1'b0;
    drive_ex(1, 0, 3'd0, 32'h102, 32'h0, 32'h0, 5'd4, 1'b1);
    tick();
    idle_ex();
    #1 check("t3_req_valid", mem_req_valid, 1);
    check("t3_write", mem_req_write, 0);
    check("t3_addr", mem_req_addr, 30'h40);
    check("t3_mask", mem_req_bytemask, 4'hF);
    check("t3_stall_req0", ex_stall, 1);
    tick();
    check("t3_req_hold", mem_req_valid, 1);
    check("t3_stall_req1", ex_stall, 1);
    mem_req_ready = 1'b1;
    #1 check("t3_stall_hs", ex_stall, 1);
    tick();
    mem_req_ready = 1'b0;
    #1 check("t3_wait_noreq", mem_req_valid, 0);
    check("t3_stall_wait0", ex_stall, 1);
    tick();
    check("t3_stall_wait1", ex_stall, 1);
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h00800000;
    #1 check("t3_stall_rsp", ex_stall, 0);
    tick();
    mem_rsp_valid = 1'b0;
    check("t3_wb_valid", wb_valid, 1);
    check("t3_wb_data", wb_rd_data, 32'hFFFFFF80);
    check("t3_wb_rd", wb_rd_addr, 4);
    check("t3_wb_we", wb_rd_we, 1);

    // LBU, same word, handshake on first cycle
    mem_req_ready = 1'b1;
    drive_ex(1, 0, 3'd4, 32'h102, 32'h0, 32'h0, 5'd6, 1'b1);
    tick();
    idle_ex();
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h00800000;
    tick();
    mem_rsp_valid = 1'b0;
    check("lbu_wb_valid", wb_valid, 1);
    check("lbu_wb_data", wb_rd_data, 32'h00000080);

    // LH at offset 2 sign-extends the upper halfword
    mem_req_ready = 1'b1;
    drive_ex(1, 0, 3'd1, 32'h2, 32'h0, 32'h0, 5'd8, 1'b1);
    tick();
    idle_ex();
    #1 check("lh_addr", mem_req_addr, 30'h0);
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h80010000;
    tick();
    mem_rsp_valid = 1'b0;
    check("lh_wb_data", wb_rd_data, 32'hFFFF8001);

    // 4: misaligned LW issues no request and traps
    drive_ex(1, 0, 3'd2, 32'h2, 32'h0, 32'h0, 5'd7, 1'b1);
    tick();
    idle_ex();
    #1 check("t4_noreq", mem_req_valid, 0);
    check("t4_stall", ex_stall, 0);
    tick();
    check("t4_wb_valid", wb_valid, 1);
    check("t4_wb_mis", wb_misaligned, 1);
    check("t4_wb_we", wb_rd_we, 0);
    check("t4_wb_data", wb_rd_data, 32'h2);

    // LD is illegal on a 32-bit bus even when aligned
    drive_ex(1, 0, 3'd3, 32'h8, 32'h0, 32'h0, 5'd7, 1'b1);
    tick();
    idle_ex();
    #1 check("ld32_noreq", mem_req_valid, 0);
    tick();
    check("ld32_wb_mis", wb_misaligned, 1);
    check("ld32_wb_data", wb_rd_data, 32'h8);

    // 5: flush while a load waits, response must be drained
    mem_req_ready = 1'b1;
    drive_ex(1, 0, 3'd2, 32'h10, 32'h0, 32'h0, 5'd9, 1'b1);
    tick();
    idle_ex();
    tick();
    mem_req_ready = 1'b0;
    flush = 1'b1;
    #1 check("t5_stall_flush", ex_stall, 1);
    tick();
    flush = 1'b0;
    #1 check("t5_stall_drain0", ex_stall, 1);
    check("t5_no_wb0", wb_valid, 0);
    check("t5_noreq", mem_req_valid, 0);
    tick();
    check("t5_stall_drain1", ex_stall, 1);
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'hDEADBEEF;
    #1 check("t5_stall_rsp", ex_stall, 1);
    tick();
    mem_rsp_valid = 1'b0;
    check("t5_no_wb1", wb_valid, 0);
    check("t5_idle_stall", ex_stall, 0);

    // Flushed store in REQ without ready drops the request at once
    drive_ex(0, 1, 3'd2, 32'h20, 32'h11223344, 32'h0, 5'd0, 1'b0);
    tick();
    idle_ex();
    #1 check("fr_req_valid", mem_req_valid, 1);
    flush = 1'b1;
    #1 check("fr_req_drop", mem_req_valid, 0);
    tick();
    flush = 1'b0;
    #1 check("fr_no_wb", wb_valid, 0);
    check("fr_idle", mem_req_valid, 0);
    check("fr_stall", ex_stall, 0);

    // 6: reset asserted while a load is in WAIT
    mem_req_ready = 1'b1;
    drive_ex(1, 0, 3'd2, 32'h14, 32'h0, 32'h0, 5'd9, 1'b1);
    tick();
    idle_ex();
    tick();
    mem_req_ready = 1'b0;
    #1 check("t6_wait_stall", ex_stall, 1);
    reset = 1'b0;
    #1 check("t6_rst_stall", ex_stall, 0);
    check("t6_rst_wb_valid", wb_valid, 0);
    check("t6_rst_wb_we", wb_rd_we, 0);
    check("t6_rst_wb_data", wb_rd_data, 0);
    check("t6_rst_req", mem_req_valid, 0);
    @(negedge clock);
    reset = 1'b1;
    tick();
    drive_ex(0, 0, 3'd0, 32'h0, 32'h0, 32'hCAFE, 5'd10, 1'b1);
    tick();
    idle_ex();
    tick();
    check("t6_alu_valid", wb_valid, 1);
    check("t6_alu_rd", wb_rd_addr, 10);
    check("t6_alu_data", wb_rd_data, 32'hCAFE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
